// File: rtl/vec_flit_adapter.sv
// Flit <-> vector adapter in front of the arbitrated vector BRAM port: gathers write
// flits into one vector write request, and serialises one read response back to flits.
//
// state      | meaning
// IDLE       | waiting for a command (cmd_ready high)
// WR_COLLECT | accepting write flits, beat 0 lands in the LSBs
// WR_REQ     | write_req held with address/data stable until write_gnt
// RD_REQ     | read_req held with address stable until read_gnt
// RD_SEND    | presenting captured vector as flits, LSB flit first
module vec_flit_adapter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 1024,
    parameter int FLIT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  wr_flit_valid,
    output logic                  wr_flit_ready,
    input  logic [FLIT_WIDTH-1:0] wr_flit_data,
    output logic                  rd_flit_valid,
    input  logic                  rd_flit_ready,
    output logic [FLIT_WIDTH-1:0] rd_flit_data,
    output logic                  rd_flit_last,
    output logic                  op_done,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] data_arbiter_send,
    output logic                  read_req,
    input  logic                  read_gnt,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0] data_arbiter_recv,
    output logic                  write_req,
    input  logic                  write_gnt
);

    localparam int BEATS  = DATA_WIDTH / FLIT_WIDTH;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_REQ,
        RD_REQ,
        RD_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  op_done_q, op_done_d;

    logic cmd_fire;
    logic wr_fire;
    logic rd_fire;

    // Request and valid outputs decode straight from the state register, so they are glitch-free.
    assign cmd_ready         = (state_q == IDLE) && !rst;
    assign wr_flit_ready     = (state_q == WR_COLLECT);
    assign write_req         = (state_q == WR_REQ);
    assign read_req          = (state_q == RD_REQ);
    assign rd_flit_valid     = (state_q == RD_SEND);
    assign rd_flit_data      = shreg_q[FLIT_WIDTH-1:0];
    assign rd_flit_last      = rd_flit_valid && (beat_q == LAST_BEAT);
    assign op_done           = op_done_q;
    assign src_addr          = src_addr_q;
    assign dst_addr          = dst_addr_q;
    assign data_arbiter_recv = wdata_q;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_fire  = wr_flit_valid && wr_flit_ready;
    assign rd_fire  = rd_flit_valid && rd_flit_ready;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        src_addr_d = src_addr_q;
        dst_addr_d = dst_addr_q;
        wdata_d    = wdata_q;
        shreg_d    = shreg_q;
        op_done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_write) begin
                        dst_addr_d = cmd_addr;
                        beat_d     = '0;
                        state_d    = WR_COLLECT;
                    end else begin
                        src_addr_d = cmd_addr;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_COLLECT: begin
                if (wr_fire) begin
                    wdata_d[int'(beat_q) * FLIT_WIDTH +: FLIT_WIDTH] = wr_flit_data;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (write_gnt) begin
                    state_d   = IDLE;
                    op_done_d = 1'b1;
                end
            end
            RD_REQ: begin
                if (read_gnt) begin
                    shreg_d = data_arbiter_send;
                    beat_d  = '0;
                    state_d = RD_SEND;
                end
            end
            RD_SEND: begin
                if (rd_fire) begin
                    shreg_d = shreg_q >> FLIT_WIDTH;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d   = IDLE;
                        op_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            src_addr_q <= '0;
            dst_addr_q <= '0;
            wdata_q    <= '0;
            shreg_q    <= '0;
            op_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            src_addr_q <= src_addr_d;
            dst_addr_q <= dst_addr_d;
            wdata_q    <= wdata_d;
            shreg_q    <= shreg_d;
            op_done_q  <= op_done_d;
        end
    end

endmodule

// File: doc/vec_flit_adapter.md
# vec_flit_adapter

- Router-side adapter sitting directly upstream of the arbitrated vector BRAM port; it drives that port's read and write request interfaces.
- Write path: takes a command plus a stream of narrow flits, assembles them into one DATA_WIDTH vector and issues a single write request.
- Read path: issues a read request, captures the returned vector and serialises it back to the router as flits.
- Executes one operation at a time.

## Interface
Parameters:
- ADDR_WIDTH, 10, vector address width (matches the BRAM port).
- DATA_WIDTH, 1024, vector width.
- FLIT_WIDTH, 64, router flit width. DATA_WIDTH must be a multiple of FLIT_WIDTH; BEATS = DATA_WIDTH/FLIT_WIDTH ≥ 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write vector, 0 = read vector.
- cmd_addr  in  ADDR_WIDTH  vector address.
- wr_flit_valid / wr_flit_ready  in / out  1 / 1  write-flit handshake.
- wr_flit_data  in  FLIT_WIDTH  write flit.
- rd_flit_valid / rd_flit_ready  out / in  1 / 1  read-flit handshake.
- rd_flit_data  out  FLIT_WIDTH  read flit.
- rd_flit_last  out  1  marks the final flit (beat BEATS-1).
- op_done  out  1  one-cycle pulse when an operation completes.
- src_addr  out  ADDR_WIDTH  read address to the arbiter.
- data_arbiter_send  in  DATA_WIDTH  read data; valid in the cycle read_gnt=1.
- read_req / read_gnt  out / in  1 / 1  read request and grant.
- dst_addr  out  ADDR_WIDTH  write address to the arbiter.
- data_arbiter_recv  out  DATA_WIDTH  write vector.
- write_req / write_gnt  out / in  1 / 1  write request and grant.

## Operation
- FSM states: IDLE, WR_COLLECT, WR_REQ, RD_REQ, RD_SEND. Beat counter is clog2(BEATS) bits wide.
- **IDLE**
  - cmd_ready = 1 (combinational; it is 0 in every other state).
  - On accept, cmd_addr is latched.
  - cmd_write=1 → WR_COLLECT with beat=0; cmd_write=0 → RD_REQ.
- **WR_COLLECT**
  - wr_flit_ready = 1.
  - Each accepted flit is written to data_arbiter_recv[beat*FLIT_WIDTH +: FLIT_WIDTH] (beat 0 = LSBs), then beat increments.
  - Accepting beat BEATS-1 → WR_REQ.
- **WR_REQ**
  - write_req = 1; dst_addr and data_arbiter_recv are held stable.
  - On an edge with write_gnt=1 → IDLE, write_req→0, op_done=1 for one cycle.
- **RD_REQ**
  - read_req = 1; src_addr is held.
  - On an edge with read_gnt=1: capture data_arbiter_send into the shift register, read_req→0, beat=0, → RD_SEND.
- **RD_SEND**
  - rd_flit_valid = 1; rd_flit_data = shreg[FLIT_WIDTH-1:0]; rd_flit_last = (beat == BEATS-1).
  - On valid & ready: shift the register right by FLIT_WIDTH and increment beat.
  - On the last beat → IDLE with op_done pulse.
- Grants outside the matching request state are ignored. A read_gnt never captures data while in WR_REQ, and vice versa.
- wr_flit_valid is ignored (ready=0) outside WR_COLLECT; flits are never accepted in the same cycle as the command.

## Timing
- **Reset values:** state=IDLE; read_req, write_req, rd_flit_valid, rd_flit_last, op_done, wr_flit_ready = 0; src_addr, dst_addr, data_arbiter_recv, shift register, beat = 0. cmd_ready is 1 from the first cycle after rst is released; commands presented while rst=1 are ignored.
- **Reset mid-operation:** returns to IDLE the next edge, drops requests, and discards partial write data or unsent read flits. No op_done is issued.
- **Request hold:** read_req/write_req are registered and held, with address and data unchanged, until the grant is sampled. The request drops on the edge after the grant cycle.
- **rd_flit_valid:** once high, stays high with rd_flit_data stable until ready. rd_flit_ready low stalls indefinitely without data loss.
- **Minimum write latency** (cmd accepted at edge 0, flits back-to-back):
  - flits at edges 1..BEATS;
  - write_req high in the cycle after edge BEATS;
  - same-cycle grant → IDLE and op_done after edge BEATS+1.
- **Minimum read latency** (cmd at edge 0):
  - read_req high in cycle 1;
  - grant in cycle 1 → first flit valid in cycle 2;
  - with ready held high, the last flit is in cycle BEATS+1 and op_done in cycle BEATS+2.
- **Throughput:** no overlap between operations; the next command is accepted in the cycle op_done is high.

## Test plan
- **Write, immediate grant:** write at addr 0x005, flits k=0..15 with data 64'h1000+k → write_req rises after 16th flit; dst_addr=0x005; data_arbiter_recv[k*64+:64]=0x1000+k; op_done exactly one cycle after write_gnt.
- **Read with stall:** read at addr 0x3FF, read_gnt asserted 3 cycles after read_req with data_arbiter_send = 1024-bit pattern {16 words 64'hA0+k}; rd_flit_ready toggled 1,0 → 16 flits 0xA0..0xAF in order; rd_flit_last only on 0xAF; data stable during stalls.
- **Delayed grants:** write_gnt held low 10 cycles → write_req, dst_addr and data_arbiter_recv constant throughout; cmd_ready=0; wr_flit_ready=0; a stray read_gnt pulse during WR_REQ has no effect.
- **Gapped flits:** wr_flit_valid with random gaps → exactly 16 flits accepted; no flits accepted in IDLE or WR_REQ.
- **Reset mid-operation:** rst asserted after 7 write flits → next cycle IDLE, write_req=0, no op_done; a subsequent read operates normally.
- **Back-to-back:** write then read of the same address with a model BRAM → the read returns the written vector; the second command is accepted in the op_done cycle.
